// File: rtl/byte_serializer_pkg.sv
// Shared constants and state encoding for the word-to-byte serializer path.
package byte_serializer_pkg;
  localparam int BS_BYTE_W = 8;
  localparam int BS_WORD_W = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;
endpackage

// File: rtl/byte_serializer_if.sv
// Word-in / byte-out handshake bundle; slave is the serializer, master the surrounding logic.
interface byte_serializer_if import byte_serializer_pkg::*; #(
  parameter int WORD_W = BS_WORD_W,
  parameter int BYTE_W = BS_BYTE_W
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/byte_serializer_shift_reg.sv
// Parallel-load shift register that walks a word out BYTE_W bits at a time.
module byte_shift_reg import byte_serializer_pkg::*; #(
  parameter int WORD_W    = BS_WORD_W,
  parameter int BYTE_W    = BS_BYTE_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_data,
  output logic [BYTE_W-1:0] byte_out
);
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [WORD_W-1:0] shifted;

  // The emitting byte always sits at the end the register shifts toward.
  if (MSB_FIRST) begin : g_msb
    assign shifted  = {sr_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    assign byte_out = sr_q[WORD_W-1 -: BYTE_W];
  end else begin : g_lsb
    assign shifted  = {{BYTE_W{1'b0}}, sr_q[WORD_W-1:BYTE_W]};
    assign byte_out = sr_q[BYTE_W-1:0];
  end

  always_comb begin
    sr_d = sr_q;
    if (load)       sr_d = load_data;
    else if (shift) sr_d = shifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end
endmodule

// File: rtl/byte_serializer.sv
// Serializes one word into WORD_W/BYTE_W bytes with valid/ready on both sides and no bubble between words.
module byte_serializer import byte_serializer_pkg::*; #(
  parameter int WORD_W    = BS_WORD_W,
  parameter int BYTE_W    = BS_BYTE_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  byte_serializer_if.slave bus
);
  localparam int NBYTES = WORD_W / BYTE_W;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_send, is_last, in_fire, out_fire, shift;
  logic [BYTE_W-1:0] emit_byte;

  assign is_send  = (state_q == S_SEND);
  assign is_last  = is_send && (cnt_q == LAST_CNT);
  // Ready for a new word while idle, or in the same cycle the final byte leaves.
  assign bus.in_ready = !is_send || (is_last && bus.out_ready);
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = is_send && bus.out_ready;
  assign shift    = out_fire && !is_last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_SEND;
          cnt_d   = '0;
        end
      end
      S_SEND: begin
        if (out_fire) begin
          if (!is_last) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (bus.in_valid) begin
            cnt_d = '0;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  byte_shift_reg #(
    .WORD_W   (WORD_W),
    .BYTE_W   (BYTE_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (in_fire),
    .shift    (shift),
    .load_data(bus.in_data),
    .byte_out (emit_byte)
  );

  // Gate the data so an idle block presents zero rather than the stale last byte.
  assign bus.out_valid = is_send;
  assign bus.out_data  = is_send ? emit_byte : '0;
  assign bus.out_last  = is_last;
  assign bus.busy      = is_send;
endmodule
